uart_prog_loader: RTL and testbench

//  Receive side of the board UART (UART_RXD, 8N1): deserialises bytes from a host
//  and packs them into 32-bit instruction words. Words are written in sequence into
//  the instruction memory that the CPU fetches from via the PC.

---
 rtl/uart_loader_pkg.sv | 11 +
 rtl/uart_rx_core.sv | 90 +++++++++
 rtl/uart_prog_loader.sv | 100 ++++++++++
 tb/tb_uart_prog_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART program loader: receiver state encoding,
// word packing geometry and the default bit period.
package uart_loader_pkg;
  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM, LSB-first shifter.
// Latency: rx_valid about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after start edge.
// No backpressure: rx_valid and frame_err are single-cycle pulses.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);
  localparam int BCNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [BCNT_W-1:0] HALF_M1 = BCNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCNT_W-1:0] FULL_M1 = BCNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta;
  logic              rxs;
  logic [1:0]        state;
  logic [BCNT_W-1:0] bcnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= ST_IDLE;
      bcnt      <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rxd;
      rxs       <= rx_meta;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            bcnt  <= '0;
          end
        end
        ST_START: begin
          // Start bit must still be low at mid-bit, otherwise treat as a glitch.
          if (bcnt == HALF_M1) begin
            bcnt    <= '0;
            bit_idx <= '0;
            state   <= rxs ? ST_IDLE : ST_DATA;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bcnt == FULL_M1) begin
            bcnt  <= '0;
            shift <= {rxs, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: begin
          if (bcnt == FULL_M1) begin
            bcnt  <= '0;
            state <= ST_IDLE;
            if (rxs) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_prog_loader.sv
// Packs received UART bytes big-endian into 32-bit words and writes them to imem.
// Latency: mem_we one cycle after the 4th byte's rx_valid; addr/word_cnt advance after.
// No backpressure: the memory must accept a write every cycle mem_we is high.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              iRST_N,
  input  logic              uart_rxd,
  input  logic              load_en,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_cnt,
  output logic              frame_err,
  output logic              overflow
);
  localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  logic              ferr_pulse;
  logic              load_en_q;
  logic              load_rise;
  logic              load_fall;
  logic              take_byte;
  logic [1:0]        byte_idx;
  logic [1:0]        idx_eff;
  logic [23:0]       word_sr;
  logic [ADDR_W-1:0] addr;
  logic              we_q;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (iRST_N),
    .rxd       (uart_rxd),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (ferr_pulse)
  );

  assign load_rise = load_en & ~load_en_q;
  assign load_fall = ~load_en & load_en_q;
  assign take_byte = rx_valid & load_en;
  // A byte landing on the load_en rise becomes byte 0 of the fresh load.
  assign idx_eff   = load_rise ? 2'd0 : byte_idx;
  // Gating keeps a write from escaping if load_en drops during the strobe cycle.
  assign mem_we    = we_q & load_en;

  always_ff @(posedge clk) begin
    if (!iRST_N) begin
      load_en_q <= 1'b0;
      byte_idx  <= '0;
      word_sr   <= '0;
      addr      <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      load_en_q <= load_en;
      we_q      <= 1'b0;
      if (mem_we) begin
        addr <= addr + 1'b1;
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
        if (mem_addr == ADDR_MAX) overflow <= 1'b1;
      end
      if (load_rise) begin
        addr      <= '0;
        word_cnt  <= '0;
        byte_idx  <= '0;
        frame_err <= 1'b0;
        overflow  <= 1'b0;
      end
      if (load_fall) byte_idx <= '0;
      if (take_byte) begin
        word_sr <= {word_sr[15:0], rx_byte};
        if (idx_eff == LAST_IDX) begin
          byte_idx  <= '0;
          we_q      <= 1'b1;
          mem_wdata <= {word_sr, rx_byte};
          mem_addr  <= addr;
        end else begin
          byte_idx <= idx_eff + 1'b1;
        end
      end
      if (ferr_pulse) begin
        frame_err <= 1'b1;
        byte_idx  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench: two loaders (ADDR_W=8 and ADDR_W=2) share one serial line,
// a word-level reference model predicts bytes and writes into scoreboard queues.
module tb_uart_prog_loader;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        iRST_N = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        load_en = 1'b0;

  logic [7:0]  rx_byte8, rx_byte2;
  logic        rx_valid8, rx_valid2;
  logic        mem_we8, mem_we2;
  logic [7:0]  mem_addr8;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata8, mem_wdata2;
  logic [8:0]  word_cnt8;
  logic [2:0]  word_cnt2;
  logic        frame_err8, frame_err2;
  logic        overflow8, overflow2;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
    .clk(clk), .iRST_N(iRST_N), .uart_rxd(uart_rxd), .load_en(load_en),
    .rx_byte(rx_byte8), .rx_valid(rx_valid8), .mem_we(mem_we8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .word_cnt(word_cnt8),
    .frame_err(frame_err8), .overflow(overflow8)
  );

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_s (
    .clk(clk), .iRST_N(iRST_N), .uart_rxd(uart_rxd), .load_en(load_en),
    .rx_byte(rx_byte2), .rx_valid(rx_valid2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .word_cnt(word_cnt2),
    .frame_err(frame_err2), .overflow(overflow2)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t        q8[$];
  wr_t        q2[$];
  logic [7:0] exp_rx8[$];
  logic [7:0] exp_rx2[$];
  logic [7:0] part[$];
  int         m_addr[2];
  int         m_cnt[2];
  bit         m_ovf[2];
  bit         m_ferr;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic int depth(input int i);
    return (i == 0) ? 256 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0;
      m_cnt[i]  = 0;
      m_ovf[i]  = 1'b0;
    end
    m_ferr = 1'b0;
    part.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    exp_rx8.push_back(b);
    exp_rx2.push_back(b);
    if (load_en) begin
      part.push_back(b);
      if (part.size() == 4) begin
        for (int i = 0; i < 2; i++) begin
          w.addr = m_addr[i];
          w.data = {part[0], part[1], part[2], part[3]};
          if (i == 0) q8.push_back(w);
          else        q2.push_back(w);
          if (m_addr[i] == depth(i) - 1) m_ovf[i] = 1'b1;
          m_addr[i] = (m_addr[i] + 1) % depth(i);
          if (m_cnt[i] < depth(i)) m_cnt[i]++;
        end
        part.delete();
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      model_byte(b);
    end else begin
      part.delete();
      m_ferr = 1'b1;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_frame(w[i*8 +: 8], 1'b1);
  endtask

  task automatic set_load(input logic v);
    if (v && !load_en) begin
      for (int i = 0; i < 2; i++) begin
        m_addr[i] = 0;
        m_cnt[i]  = 0;
        m_ovf[i]  = 1'b0;
      end
      m_ferr = 1'b0;
      part.delete();
    end
    if (!v) part.delete();
    load_en = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain_and_check(input string tag);
    repeat (4 * CPB) @(negedge clk);
    chk({tag, "_rx_pending"}, exp_rx8.size(), 0);
    chk({tag, "_wr8_pending"}, q8.size(), 0);
    chk({tag, "_wr2_pending"}, q2.size(), 0);
    chk({tag, "_word_cnt8"}, word_cnt8, m_cnt[0]);
    chk({tag, "_word_cnt2"}, word_cnt2, m_cnt[1]);
    chk({tag, "_overflow8"}, overflow8, m_ovf[0]);
    chk({tag, "_overflow2"}, overflow2, m_ovf[1]);
    chk({tag, "_frame_err8"}, frame_err8, m_ferr);
    chk({tag, "_frame_err2"}, frame_err2, m_ferr);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_byte"}, {rx_byte8, rx_byte2}, 0);
    chk({tag, "_rx_valid"}, {rx_valid8, rx_valid2}, 0);
    chk({tag, "_mem_we"}, {mem_we8, mem_we2}, 0);
    chk({tag, "_mem_addr"}, {mem_addr8, mem_addr2}, 0);
    chk({tag, "_wdata8"}, mem_wdata8, 0);
    chk({tag, "_wdata2"}, mem_wdata2, 0);
    chk({tag, "_word_cnt"}, {word_cnt8, word_cnt2}, 0);
    chk({tag, "_flags"}, {frame_err8, frame_err2, overflow8, overflow2}, 0);
  endtask

  // Scoreboard monitor: every DUT output event pops its expected value.
  always @(negedge clk) begin
    wr_t w;
    if (iRST_N) begin
      if (rx_valid8) begin
        if (exp_rx8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected8: got %h expected no byte", rx_byte8);
        end else chk("rx_byte8", rx_byte8, exp_rx8.pop_front());
      end
      if (rx_valid2) begin
        if (exp_rx2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected2: got %h expected no byte", rx_byte2);
        end else chk("rx_byte2", rx_byte2, exp_rx2.pop_front());
      end
      if (mem_we8) begin
        chk("we8_load_en", load_en, 1);
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_unexpected8: got addr %h data %h expected no write", mem_addr8, mem_wdata8);
        end else begin
          w = q8.pop_front();
          chk("wr8_addr", mem_addr8, w.addr);
          chk("wr8_data", mem_wdata8, w.data);
        end
      end
      if (mem_we2) begin
        chk("we2_load_en", load_en, 1);
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_unexpected2: got addr %h data %h expected no write", mem_addr2, mem_wdata2);
        end else begin
          w = q2.pop_front();
          chk("wr2_addr", mem_addr2, w.addr);
          chk("wr2_data", mem_wdata2, w.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_reset("por");
    iRST_N = 1'b1;
    repeat (4) @(negedge clk);

    // Bytes reported only, never written.
    send_frame(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    drain_and_check("t1");

    set_load(1'b1);
    send_word(32'h20100005);
    drain_and_check("t2");

    set_load(1'b0);
    set_load(1'b1);
    for (int i = 0; i < 8; i++) send_word($urandom);
    drain_and_check("t3");
    chk("t3_word_cnt8_const", word_cnt8, 8);

    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_word($urandom);
    drain_and_check("t4");
    chk("t4_frame_err_const", frame_err8, 1);

    set_load(1'b0);
    set_load(1'b1);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    drain_and_check("t5_glitch");

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    iRST_N = 1'b0;
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("mid_rst");
    model_clear();
    iRST_N = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_word($urandom);
    drain_and_check("t5_after_rst");

    set_load(1'b0);
    set_load(1'b1);
    for (int i = 0; i < 5; i++) send_word($urandom);
    drain_and_check("t6");
    chk("t6_word_cnt2_sat", word_cnt2, 4);
    chk("t6_overflow2_const", overflow2, 1);

    // Partial word dropped by load_en fall; addr and word_cnt hold.
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    set_load(1'b0);
    set_load(1'b1);
    for (int i = 0; i < 3; i++) send_word($urandom);
    drain_and_check("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
